// File: rtl/option_line_streamer.sv
// Transmit side of the solver option stream: header + options per line, one bubble
// between lines, and per-line recount of survivors written back into the option FIFO.
module option_line_streamer #(
    parameter int OPT_W     = 16,
    parameter int MAX_LINES = 11,
    parameter int CNT_W     = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [3:0]                   num_lines,
    input  logic [MAX_LINES*CNT_W-1:0]   init_amnt,
    input  logic [OPT_W-1:0]             fifo_rdata,
    input  logic                         fifo_empty,
    output logic                         fifo_rd,
    input  logic                         out_ready,
    output logic [OPT_W-1:0]             option_out,
    output logic                         option_valid,
    output logic                         is_header,
    input  logic                         pb_valid,
    input  logic [OPT_W-1:0]             pb_data,
    input  logic                         pb_line_end,
    output logic                         fifo_wr,
    output logic [OPT_W-1:0]             fifo_wdata,
    input  logic                         solved,
    output logic [MAX_LINES*CNT_W-1:0]   amnt,
    output logic [7:0]                   round,
    output logic                         busy,
    output logic                         done,
    output logic                         unsat
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_OPT, S_GAP, S_DONE} state_t;

    state_t                              r_state, w_next;
    logic [MAX_LINES-1:0][CNT_W-1:0]     r_amnt;
    logic [3:0]                          r_line_ptr, r_pb_ptr;
    logic [CNT_W-1:0]                    r_opt_cnt, r_surv_cnt;
    logic [7:0]                          r_round;
    logic                                r_unsat;

    logic [CNT_W-1:0]                    w_cur_amnt, w_pb_cnt;
    logic                                w_hs_opt, w_last_line, w_pb_last, w_start;

    // Lane select kept as a compare loop so an out-of-range pointer reads as 0.
    always_comb begin
        w_cur_amnt = '0;
        for (int i = 0; i < MAX_LINES; i++)
            if (r_line_ptr == 4'(i)) w_cur_amnt = r_amnt[i];
    end

    assign w_start     = (r_state == S_IDLE) && start;
    assign w_hs_opt    = (r_state == S_OPT) && !fifo_empty && out_ready;
    assign w_last_line = (r_line_ptr >= num_lines - 4'd1);
    assign w_pb_last   = (r_pb_ptr >= num_lines - 4'd1);
    assign w_pb_cnt    = (pb_valid && (r_surv_cnt != '1)) ? r_surv_cnt + 1'b1 : r_surv_cnt;

    always_comb begin
        option_valid = 1'b0;
        is_header    = 1'b0;
        option_out   = '0;
        case (r_state)
            S_HDR: begin
                option_valid = 1'b1;
                is_header    = 1'b1;
                option_out   = OPT_W'(r_line_ptr);
            end
            S_OPT: begin
                option_valid = !fifo_empty;
                option_out   = fifo_rdata;
            end
            default: ;
        endcase
    end

    assign fifo_rd    = w_hs_opt;
    assign fifo_wr    = pb_valid;
    assign fifo_wdata = pb_valid ? pb_data : '0;
    assign busy       = (r_state == S_HDR) || (r_state == S_OPT) || (r_state == S_GAP);
    assign done       = (r_state == S_DONE);
    assign amnt       = r_amnt;
    assign round      = r_round;
    assign unsat      = r_unsat;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_HDR;
            S_HDR:  if (out_ready) w_next = (w_cur_amnt != '0) ? S_OPT : S_GAP;
            S_OPT:  if (w_hs_opt && (r_opt_cnt == w_cur_amnt - 1'b1)) w_next = S_GAP;
            S_GAP:  w_next = S_HDR;
            S_DONE: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        // Solved preempts everything, dropping whatever line is in flight.
        if (solved && (r_state != S_IDLE)) w_next = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_line_ptr <= '0;
            r_opt_cnt  <= '0;
            r_round    <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) r_line_ptr <= '0;
            if ((r_state == S_HDR) && out_ready) r_opt_cnt <= '0;
            if (w_hs_opt) r_opt_cnt <= r_opt_cnt + 1'b1;
            if (r_state == S_GAP) begin
                if (w_last_line) begin
                    r_line_ptr <= '0;
                    r_round    <= r_round + 8'd1;
                end else begin
                    r_line_ptr <= r_line_ptr + 4'd1;
                end
            end
        end
    end

    // Put-back side runs regardless of stream state; a line commit overrides a start load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amnt     <= '0;
            r_pb_ptr   <= '0;
            r_surv_cnt <= '0;
            r_unsat    <= 1'b0;
        end else begin
            if (w_start) begin
                r_amnt     <= init_amnt;
                r_pb_ptr   <= '0;
                r_surv_cnt <= '0;
            end
            if (pb_line_end) begin
                for (int i = 0; i < MAX_LINES; i++)
                    if (r_pb_ptr == 4'(i)) r_amnt[i] <= w_pb_cnt;
                r_surv_cnt <= '0;
                r_pb_ptr   <= w_pb_last ? 4'd0 : r_pb_ptr + 4'd1;
                if (w_pb_cnt == '0) r_unsat <= 1'b1;
            end else if (pb_valid) begin
                r_surv_cnt <= w_pb_cnt;
            end
        end
    end

endmodule
